// File: rtl/operand_forward_unit_pkg.sv
// Shared types for the LC-3b EX-stage operand bypass and load-hazard unit.
package operand_forward_unit_pkg;

    localparam int unsigned LC3B_REG_W  = 3;
    localparam int unsigned LC3B_WORD_W = 16;
    localparam int unsigned PERF_W      = 32;

    typedef logic [LC3B_REG_W-1:0]  lc3b_reg;
    typedef logic [LC3B_WORD_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_RET,
        FWD_WB,
        FWD_MEM
    } fwd_src_t;

    typedef enum logic {
        FWD_RUN,
        FWD_LOAD_WAIT
    } fwd_state_t;

endpackage

// File: rtl/operand_forward_unit_if.sv
// Pipeline-side bundle for operand_forward_unit; OPERAND_FWD_PERF_EN adds the perf counters.
interface operand_forward_unit_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned WORD_W   = 16
);
    localparam int unsigned REG_W = $clog2(NUM_REGS);

    logic              pipe_stall;
    logic              ex_valid;
    logic [REG_W-1:0]  ex_sr1;
    logic [REG_W-1:0]  ex_sr2;
    logic              ex_uses_sr1;
    logic              ex_uses_sr2;
    logic [WORD_W-1:0] ex_rf_sr1;
    logic [WORD_W-1:0] ex_rf_sr2;
    logic              mem_valid;
    logic              mem_we;
    logic [REG_W-1:0]  mem_dest;
    logic              mem_is_load;
    logic              mem_data_ok;
    logic [WORD_W-1:0] mem_out;
    logic              wb_valid;
    logic              wb_we;
    logic [REG_W-1:0]  wb_dest;
    logic [WORD_W-1:0] wb_out;
    logic [WORD_W-1:0] ex_op1;
    logic [WORD_W-1:0] ex_op2;
    logic              hazard_stall;
    logic              fwd_state;
`ifdef OPERAND_FWD_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       fwd_hits;
`endif

    modport master (
        output pipe_stall, ex_valid, ex_sr1, ex_sr2, ex_uses_sr1, ex_uses_sr2,
               ex_rf_sr1, ex_rf_sr2, mem_valid, mem_we, mem_dest, mem_is_load,
               mem_data_ok, mem_out, wb_valid, wb_we, wb_dest, wb_out,
        input  ex_op1, ex_op2, hazard_stall, fwd_state
`ifdef OPERAND_FWD_PERF_EN
               , stall_cycles, fwd_hits
`endif
    );

    modport slave (
        input  pipe_stall, ex_valid, ex_sr1, ex_sr2, ex_uses_sr1, ex_uses_sr2,
               ex_rf_sr1, ex_rf_sr2, mem_valid, mem_we, mem_dest, mem_is_load,
               mem_data_ok, mem_out, wb_valid, wb_we, wb_dest, wb_out,
        output ex_op1, ex_op2, hazard_stall, fwd_state
`ifdef OPERAND_FWD_PERF_EN
               , stall_cycles, fwd_hits
`endif
    );

endinterface

// File: rtl/operand_forward_unit_bypass_mux.sv
// Per-operand priority bypass select: MEM, then WB, then retired buffer, then regfile.
module operand_bypass_mux
    import operand_forward_unit_pkg::*;
#(
    parameter int unsigned REG_W  = 3,
    parameter int unsigned WORD_W = 16
) (
    input  logic [REG_W-1:0]  sr,
    input  logic              use_en,
    input  logic              mem_wr,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              wb_wr,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [WORD_W-1:0] wb_data,
    input  logic              ret_wr,
    input  logic [REG_W-1:0]  ret_dest,
    input  logic [WORD_W-1:0] ret_data,
    input  logic [WORD_W-1:0] rf_data,
    output logic [WORD_W-1:0] operand_c,
    output fwd_src_t          src_c
);

    always_comb begin
        operand_c = rf_data;
        src_c     = FWD_RF;
        if (use_en && mem_wr && (mem_dest == sr)) begin
            operand_c = mem_data;
            src_c     = FWD_MEM;
        end else if (use_en && wb_wr && (wb_dest == sr)) begin
            operand_c = wb_data;
            src_c     = FWD_WB;
        end else if (use_en && ret_wr && (ret_dest == sr)) begin
            operand_c = ret_data;
            src_c     = FWD_RET;
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// EX-stage operand bypass, retired-writeback buffer and load-use stall FSM.
// Optional perf counters enabled with OPERAND_FWD_PERF_EN.
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned WORD_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    operand_forward_unit_if.slave bus
);

    localparam int unsigned REG_W = $clog2(NUM_REGS);

    logic              ret_valid;
    logic [REG_W-1:0]  ret_dest;
    logic [WORD_W-1:0] ret_data;
    fwd_state_t        state;
    fwd_state_t        state_nxt;
    fwd_src_t          src1_c;
    fwd_src_t          src2_c;
    logic [WORD_W-1:0] op1_c;
    logic [WORD_W-1:0] op2_c;
    logic              need_wait_c;
    logic              stall_c;
    logic              advance_c;

    operand_bypass_mux #(.REG_W(REG_W), .WORD_W(WORD_W)) u_mux1 (
        .sr        (bus.ex_sr1),
        .use_en    (bus.ex_valid & bus.ex_uses_sr1),
        .mem_wr    (bus.mem_valid & bus.mem_we),
        .mem_dest  (bus.mem_dest),
        .mem_data  (bus.mem_out),
        .wb_wr     (bus.wb_valid & bus.wb_we),
        .wb_dest   (bus.wb_dest),
        .wb_data   (bus.wb_out),
        .ret_wr    (ret_valid),
        .ret_dest  (ret_dest),
        .ret_data  (ret_data),
        .rf_data   (bus.ex_rf_sr1),
        .operand_c (op1_c),
        .src_c     (src1_c)
    );

    operand_bypass_mux #(.REG_W(REG_W), .WORD_W(WORD_W)) u_mux2 (
        .sr        (bus.ex_sr2),
        .use_en    (bus.ex_valid & bus.ex_uses_sr2),
        .mem_wr    (bus.mem_valid & bus.mem_we),
        .mem_dest  (bus.mem_dest),
        .mem_data  (bus.mem_out),
        .wb_wr     (bus.wb_valid & bus.wb_we),
        .wb_dest   (bus.wb_dest),
        .wb_data   (bus.wb_out),
        .ret_wr    (ret_valid),
        .ret_dest  (ret_dest),
        .ret_data  (ret_data),
        .rf_data   (bus.ex_rf_sr2),
        .operand_c (op2_c),
        .src_c     (src2_c)
    );

    // A MEM hit on an unfinished load must hold EX; reset kills the request immediately.
    assign need_wait_c = ((src1_c == FWD_MEM) || (src2_c == FWD_MEM))
                         && bus.mem_is_load && !bus.mem_data_ok;
    assign stall_c     = need_wait_c && !rst;
    assign advance_c   = !bus.pipe_stall && !stall_c;

    assign bus.ex_op1       = op1_c;
    assign bus.ex_op2       = op2_c;
    assign bus.hazard_stall = stall_c;
    assign bus.fwd_state    = (state == FWD_LOAD_WAIT);

    // Regfile has no write-through, so the last retired write is replayed for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid <= 1'b0;
            ret_dest  <= '0;
            ret_data  <= '0;
        end else if (advance_c) begin
            ret_valid <= bus.wb_valid & bus.wb_we;
            ret_dest  <= bus.wb_dest;
            ret_data  <= bus.wb_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FWD_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush (mem_valid low) clears need_wait, so it also releases LOAD_WAIT.
    always_comb begin
        state_nxt = state;
        if (!bus.pipe_stall) begin
            case (state)
                FWD_RUN:       if (need_wait_c)  state_nxt = FWD_LOAD_WAIT;
                FWD_LOAD_WAIT: if (!need_wait_c) state_nxt = FWD_RUN;
                default:                         state_nxt = FWD_RUN;
            endcase
        end
    end

`ifdef OPERAND_FWD_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] hit_cnt;
    logic              any_hit_c;

    assign any_hit_c = (src1_c != FWD_RF) || (src2_c != FWD_RF);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            hit_cnt   <= '0;
        end else begin
            if (stall_c && !bus.pipe_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (any_hit_c && advance_c && (hit_cnt != '1))
                hit_cnt <= hit_cnt + PERF_W'(1);
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.fwd_hits     = hit_cnt;
`endif

endmodule
